store_checker: RTL and testbench

Synthesizable, parametrised store-stream checker for pipeline-risc-v. It replaces hand-coded negedge `if/else` store monitors with a loadable table of expected `(address, data)` store pairs. It snoops the core's data-memory write port, matches every store against the table in any order, and ignores a configurable scratch-address window. It counts passes, terminates on a done sentinel store, and flags failure on an unexpected store or a watchdog timeout.

---
 rtl/store_checker.sv | 189 ++++++++++++++++++
 tb/tb_store_checker.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/store_checker.sv
// Store-stream checker: matches core data-memory writes against a loadable table of expected (address, data) pairs.
// Optional simulation trace is enabled by defining STORE_CHECKER_TRACE_EN.
module store_checker #(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter int                DEPTH     = 64,
  parameter logic [ADDR_W-1:0] IGN_LO    = ADDR_W'(32'd96),
  parameter logic [ADDR_W-1:0] IGN_HI    = ADDR_W'(32'd99),
  parameter logic [ADDR_W-1:0] DONE_ADDR = ADDR_W'(32'd40),
  parameter logic [DATA_W-1:0] DONE_DATA = DATA_W'(32'd30),
  parameter int unsigned       TIMEOUT   = 32'd100000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     MemWrite,
  input  logic [ADDR_W-1:0]        DataAdr,
  input  logic [DATA_W-1:0]        WriteData,
  input  logic                     cfg_we,
  input  logic                     cfg_clear,
  input  logic [$clog2(DEPTH)-1:0] cfg_idx,
  input  logic [ADDR_W-1:0]        cfg_addr,
  input  logic [DATA_W-1:0]        cfg_data,
  input  logic                     cfg_cnt,
  input  logic                     start,
  output logic [1:0]               state,
  output logic [$clog2(DEPTH):0]   pass_count,
  output logic [$clog2(DEPTH):0]   hit_count,
  output logic                     timeout,
  output logic [ADDR_W-1:0]        fail_addr,
  output logic [DATA_W-1:0]        fail_data
);

  localparam int IW   = $clog2(DEPTH);
  localparam int CW   = IW + 1;
  localparam int WD_W = (TIMEOUT > 32'd1) ? $clog2(TIMEOUT + 32'd1) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [1:0] S_FAIL = 2'd3;

  logic [DEPTH-1:0]  tbl_valid_r;
  logic [DEPTH-1:0]  tbl_cnt_r;
  logic [DEPTH-1:0]  tbl_hit_r;
  logic [ADDR_W-1:0] tbl_addr_r [DEPTH];
  logic [DATA_W-1:0] tbl_data_r [DEPTH];
  logic [WD_W-1:0]   wdog_r;

  logic [DEPTH-1:0]  match_s;
  logic [DEPTH-1:0]  fresh_s;
  logic              any_fresh_s;
  logic              dup_s;
  logic [IW-1:0]     new_idx_s;
  logic              is_done_s;
  logic              in_ign_s;
  logic              store_s;
  logic              wd_expire_s;

  // Per-entry compare of the current store against the table
  always_comb begin
    match_s = '0;
    for (int i = 0; i < DEPTH; i++) begin
      match_s[i] = tbl_valid_r[i] && (tbl_addr_r[i] == DataAdr) && (tbl_data_r[i] == WriteData);
    end
  end

  // Lowest-index unhit match wins; the descending scan leaves the smallest index last
  always_comb begin
    new_idx_s = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      new_idx_s = fresh_s[i] ? IW'(i) : new_idx_s;
    end
  end

  assign fresh_s     = match_s & ~tbl_hit_r;
  assign any_fresh_s = |fresh_s;
  assign dup_s       = |(match_s & tbl_hit_r);
  assign is_done_s   = (DataAdr == DONE_ADDR) && (WriteData == DONE_DATA);
  assign in_ign_s    = (DataAdr >= IGN_LO) && (DataAdr <= IGN_HI);
  assign store_s     = (state == S_RUN) && MemWrite;
  assign wd_expire_s = (TIMEOUT != 32'd0) && (wdog_r == WD_W'(TIMEOUT - 32'd1));

  // Table payload: written only while idle, never reset so a table survives a rerun
  always_ff @(posedge clk) begin
    if ((state == S_IDLE) && cfg_we && !reset) begin
      tbl_addr_r[cfg_idx] <= cfg_addr;
      tbl_data_r[cfg_idx] <= cfg_data;
    end
  end

  // Valid/cnt/hit flags; clear lands before a same-cycle write because the later NBA wins
  always_ff @(posedge clk) begin
    if (reset) begin
      tbl_hit_r <= '0;
    end else if (state == S_IDLE) begin
      if (start) begin
        tbl_hit_r <= '0;
      end
      if (cfg_clear) begin
        tbl_valid_r <= '0;
      end
      if (cfg_we) begin
        tbl_valid_r[cfg_idx] <= 1'b1;
        tbl_cnt_r[cfg_idx]   <= cfg_cnt;
        tbl_hit_r[cfg_idx]   <= 1'b0;
      end
    end else if (store_s && !is_done_s && any_fresh_s) begin
      tbl_hit_r[new_idx_s] <= 1'b1;
    end
  end

  // Run-state control, counters, watchdog and failure capture
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      pass_count <= '0;
      hit_count  <= '0;
      timeout    <= 1'b0;
      fail_addr  <= '0;
      fail_data  <= '0;
      wdog_r     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state      <= S_RUN;
            pass_count <= '0;
            hit_count  <= '0;
            wdog_r     <= '0;
          end
        end
        S_RUN: begin
          if (MemWrite) begin
            wdog_r <= '0;
            if (is_done_s) begin
              state <= S_DONE;
            end else if (any_fresh_s) begin
              hit_count  <= hit_count + CW'(1);
              pass_count <= pass_count + CW'(tbl_cnt_r[new_idx_s]);
            end else if (!dup_s && !in_ign_s) begin
              state     <= S_FAIL;
              fail_addr <= DataAdr;
              fail_data <= WriteData;
            end
          end else if (wd_expire_s) begin
            state     <= S_FAIL;
            timeout   <= 1'b1;
            fail_addr <= '0;
            fail_data <= '0;
          end else if (wdog_r != {WD_W{1'b1}}) begin
            wdog_r <= wdog_r + WD_W'(1);
          end
        end
        default: begin
          state <= state;
        end
      endcase
    end
  end

`ifdef STORE_CHECKER_TRACE_EN
  // Simulation-only event log; stops the run on entry to a terminal state
  always @(posedge clk) begin
    if (!reset && (state == S_RUN)) begin
      if (MemWrite) begin
        if (is_done_s) begin
          $display("%0d/%0d PASSED", pass_count, DEPTH);
          $stop;
        end else if (any_fresh_s) begin
          $display("%10s OK  entry %0d", "store", new_idx_s);
        end else if (dup_s) begin
          $display("%10s OK  duplicate", "store");
        end else if (in_ign_s) begin
          $display("%10s ignored addr=%0d", "store", DataAdr);
        end else begin
          $display("store_checker stopped: addr=%0d data=%0d timeout=0", DataAdr, WriteData);
          $stop;
        end
      end else if (wd_expire_s) begin
        $display("store_checker stopped: addr=0 data=0 timeout=1");
        $stop;
      end
    end
  end
`else
  localparam bit TRACE_EN = 1'b0;
`endif

endmodule

// File: tb/tb_store_checker.sv
// Randomized + directed bench for store_checker against a table-level reference model.
module tb_store_checker;

  localparam int DEPTH = 64;
  localparam int TMO   = 10;

  logic        clk = 1'b0;
  logic        reset, MemWrite, cfg_we, cfg_clear, cfg_cnt, start;
  logic [31:0] DataAdr, WriteData, cfg_addr, cfg_data;
  logic [5:0]  cfg_idx;
  logic [1:0]  state;
  logic [6:0]  pass_count, hit_count;
  logic        timeout;
  logic [31:0] fail_addr, fail_data;

  int n_checks = 0;
  int n_pass   = 0;

  // reference model state
  int          m_state, m_pass, m_hit, m_wd;
  bit          m_to;
  logic [31:0] m_fa, m_fd;
  bit          m_valid [DEPTH];
  bit          m_cnt   [DEPTH];
  bit          m_hitb  [DEPTH];
  logic [31:0] m_addr  [DEPTH];
  logic [31:0] m_data  [DEPTH];
  logic [31:0] pool_a [$];
  logic [31:0] pool_d [$];

  always #5 clk = ~clk;

  store_checker #(.TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .MemWrite(MemWrite), .DataAdr(DataAdr), .WriteData(WriteData),
    .cfg_we(cfg_we), .cfg_clear(cfg_clear), .cfg_idx(cfg_idx), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .cfg_cnt(cfg_cnt), .start(start), .state(state),
    .pass_count(pass_count), .hit_count(hit_count), .timeout(timeout),
    .fail_addr(fail_addr), .fail_data(fail_data)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic model_edge();
    if (reset) begin
      m_state = 0; m_pass = 0; m_hit = 0; m_wd = 0; m_to = 0; m_fa = 0; m_fd = 0;
      foreach (m_hitb[i]) m_hitb[i] = 0;
    end else if (m_state == 0) begin
      if (cfg_clear) foreach (m_valid[i]) m_valid[i] = 0;
      if (cfg_we) begin
        m_valid[cfg_idx] = 1; m_hitb[cfg_idx] = 0; m_cnt[cfg_idx] = cfg_cnt;
        m_addr[cfg_idx] = cfg_addr; m_data[cfg_idx] = cfg_data;
      end
      if (start) begin
        m_state = 1; m_pass = 0; m_hit = 0; m_wd = 0;
        foreach (m_hitb[i]) m_hitb[i] = 0;
      end
    end else if (m_state == 1) begin
      if (MemWrite) begin
        int  first;
        bit  dup;
        first = -1; dup = 0; m_wd = 0;
        for (int i = 0; i < DEPTH; i++)
          if (m_valid[i] && m_addr[i] == DataAdr && m_data[i] == WriteData) begin
            if (!m_hitb[i] && first < 0) first = i;
            if (m_hitb[i]) dup = 1;
          end
        if (DataAdr == 32'd40 && WriteData == 32'd30) m_state = 2;
        else if (first >= 0) begin
          m_hitb[first] = 1; m_hit++; if (m_cnt[first]) m_pass++;
        end else if (dup || (DataAdr >= 32'd96 && DataAdr <= 32'd99)) begin
        end else begin
          m_state = 3; m_fa = DataAdr; m_fd = WriteData;
        end
      end else begin
        m_wd++;
        if (m_wd >= TMO) begin m_state = 3; m_to = 1; m_fa = 0; m_fd = 0; end
      end
    end
  endtask

  task automatic compare_all();
    check_eq("state", state, m_state);
    check_eq("pass_count", pass_count, m_pass);
    check_eq("hit_count", hit_count, m_hit);
    check_eq("timeout", timeout, m_to);
    check_eq("fail_addr", fail_addr, m_fa);
    check_eq("fail_data", fail_data, m_fd);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
    MemWrite = 0; cfg_we = 0; cfg_clear = 0; start = 0; cfg_cnt = 0;
  endtask

  task automatic do_reset();
    reset = 1; step(); reset = 0;
  endtask

  task automatic load(input int idx, input logic [31:0] a, input logic [31:0] d, input bit c);
    cfg_we = 1; cfg_idx = 6'(idx); cfg_addr = a; cfg_data = d; cfg_cnt = c; step();
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    MemWrite = 1; DataAdr = a; WriteData = d; step();
  endtask

  task automatic go();
    start = 1; step();
  endtask

  initial begin
    reset = 1; MemWrite = 0; cfg_we = 0; cfg_clear = 0; cfg_cnt = 0; start = 0;
    DataAdr = 0; WriteData = 0; cfg_idx = 0; cfg_addr = 0; cfg_data = 0;
    do_reset();
    check_eq("reset_state", state, 2'd0);
    check_eq("reset_hit", hit_count, 7'd0);
    check_eq("reset_fail_addr", fail_addr, 32'd0);

    // two entries hit out of order, then ignored store and sentinel
    cfg_clear = 1; step();
    load(0, 32'd100, 32'd25, 1'b1);
    load(1, 32'd104, 32'd4096, 1'b0);
    go();
    store(32'd104, 32'd4096);
    store(32'd100, 32'd25);
    check_eq("t1_hit", hit_count, 7'd2);
    check_eq("t1_pass", pass_count, 7'd1);
    check_eq("t1_state", state, 2'd1);
    store(32'd97, 32'd5);
    check_eq("t1_ign_state", state, 2'd1);
    store(32'd40, 32'd30);
    check_eq("t1_done", state, 2'd2);
    check_eq("t1_done_hit", hit_count, 7'd2);

    // unexpected store
    do_reset(); go();
    store(32'd108, 32'd7);
    check_eq("t2_fail", state, 2'd3);
    check_eq("t2_fa", fail_addr, 32'd108);
    check_eq("t2_fd", fail_data, 32'd7);
    check_eq("t2_to", timeout, 1'b0);
    store(32'd40, 32'd30);
    check_eq("t2_sticky", state, 2'd3);

    // watchdog
    do_reset(); go();
    for (int k = 0; k < TMO - 1; k++) step();
    check_eq("t3_pre", state, 2'd1);
    step();
    check_eq("t3_fail", state, 2'd3);
    check_eq("t3_to", timeout, 1'b1);
    check_eq("t3_fa", fail_addr, 32'd0);

    // duplicate entries
    do_reset(); cfg_clear = 1; step();
    load(0, 32'd100, 32'd25, 1'b1);
    load(1, 32'd100, 32'd25, 1'b1);
    go();
    store(32'd100, 32'd25); check_eq("t4_h1", hit_count, 7'd1);
    store(32'd100, 32'd25); check_eq("t4_h2", hit_count, 7'd2);
    store(32'd100, 32'd25); check_eq("t4_h3", hit_count, 7'd2);
    check_eq("t4_state", state, 2'd1);

    // reset mid-run retains table, clears hits
    do_reset(); go();
    store(32'd100, 32'd25);
    do_reset(); go();
    store(32'd100, 32'd25);
    check_eq("t5_hit", hit_count, 7'd1);

    // randomized rounds against the model
    for (int r = 0; r < 30; r++) begin
      do_reset();
      pool_a.delete(); pool_d.delete();
      cfg_clear = 1;
      if ($urandom_range(0, 3) == 0) begin
        cfg_we = 1; cfg_idx = 6'($urandom_range(0, 63)); cfg_addr = 32'd100; cfg_data = 32'd1;
        cfg_cnt = 1'($urandom_range(0, 1));
        pool_a.push_back(32'd100); pool_d.push_back(32'd1);
      end
      step();
      for (int e = 0; e < int'($urandom_range(1, 8)); e++) begin
        logic [31:0] a, d;
        a = 32'd100 + 32'd4 * 32'($urandom_range(0, 5));
        d = 32'($urandom_range(0, 3));
        pool_a.push_back(a); pool_d.push_back(d);
        load(int'($urandom_range(0, 63)), a, d, 1'($urandom_range(0, 1)));
      end
      if ($urandom_range(0, 2) == 0) begin MemWrite = 1; DataAdr = 32'd40; WriteData = 32'd30; end
      go();
      for (int s = 0; s < 30 && m_state == 1; s++) begin
        int kind, p;
        kind = int'($urandom_range(0, 19));
        if ($urandom_range(0, 7) == 0) begin
          cfg_we = 1; cfg_idx = 6'($urandom_range(0, 63)); cfg_addr = 32'd108; cfg_data = 32'd9;
        end
        if (kind < 12) begin
          p = int'($urandom_range(0, pool_a.size() - 1));
          store(pool_a[p], pool_d[p]);
        end else if (kind < 15) store(32'd96 + 32'($urandom_range(0, 3)), 32'($urandom));
        else if (kind < 17) begin
          for (int g = 0; g < int'($urandom_range(1, 12)); g++) step();
        end else if (kind < 19) store(32'd92 + 32'd4 * 32'($urandom_range(0, 6)), 32'($urandom_range(0, 3)));
        else store(32'd40, 32'd30);
      end
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
